led_bank_ctrl: RTL



---
 rtl/led_bank_ctrl_pkg.sv | 25 ++
 rtl/led_timebase.sv | 65 ++++++
 rtl/led_bank_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_bank_ctrl_pkg.sv
// Shared constants for the banked LED peripheral.
// Holds register offsets within the window, the bank width and the brightness reset value.
package led_bank_ctrl_pkg;

    localparam int         BANK_W       = 8;
    localparam logic [7:0] BRIGHT_RESET = 8'hFF;
    localparam int         VAL_OFS      = 0;

    function automatic int blink_ofs(int n);
        return n;
    endfunction

    function automatic int div_ofs(int n);
        return 2 * n;
    endfunction

    function automatic int bright_ofs(int n);
        return 2 * n + 1;
    endfunction

    function automatic int status_ofs(int n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Blink and PWM timebase: prescaler, blink counter/phase and free-running PWM counter.
// Ports: clk, reset (sync, active-high), blink_div, bright, restart -> blink_phase, pwm_on.
module led_timebase #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] blink_div,
    input  logic [7:0] bright,
    input  logic       restart,
    output logic       blink_phase,
    output logic       pwm_on
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    pwm_q, pwm_d;
    logic          phase_q, phase_d;
    logic          tick;

    always_comb begin
        tick    = (pre_q == PRE_MAX);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        pwm_d   = pwm_q + 8'd1;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // A divider write beats a coincident tick so the period restarts cleanly.
        if (restart) begin
            pre_d   = '0;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (blink_div == 8'd0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (cnt_q == blink_div - 8'd1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            pwm_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;
    assign pwm_on      = (bright == 8'hFF) || (pwm_q < bright);

endmodule

// File: rtl/led_bank_ctrl.sv
// Memory-mapped LED bank controller with per-LED blink and global PWM brightness.
// Ports: CLK, RESET (sync, active-high), BUS_ADDR, BUS_DATA (tri-state), BUS_WE -> LED_OUT.
module led_bank_ctrl
    import led_bank_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         NUM_BANKS = 2,
    parameter int         PRESCALE  = 50000
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [7:0]                  BUS_ADDR,
    inout  wire  [7:0]                  BUS_DATA,
    input  logic                        BUS_WE,
    output logic [BANK_W*NUM_BANKS-1:0] LED_OUT
);

    localparam int         W      = BANK_W * NUM_BANKS;
    localparam logic [7:0] V_OFS  = 8'(VAL_OFS);
    localparam logic [7:0] B_OFS  = 8'(blink_ofs(NUM_BANKS));
    localparam logic [7:0] D_OFS  = 8'(div_ofs(NUM_BANKS));
    localparam logic [7:0] BR_OFS = 8'(bright_ofs(NUM_BANKS));
    localparam logic [7:0] S_OFS  = 8'(status_ofs(NUM_BANKS));

    logic [NUM_BANKS-1:0][BANK_W-1:0] val_q, val_d;
    logic [NUM_BANKS-1:0][BANK_W-1:0] blk_q, blk_d;
    logic [7:0] div_q, div_d;
    logic [7:0] bright_q, bright_d;
    logic [7:0] rd_buf_q, rd_buf_d;
    logic       oe_q, oe_d;

    logic [7:0] ofs;
    logic       in_win;
    logic       restart;
    logic [7:0] rd_data;
    logic       blink_phase;
    logic       pwm_on;
    logic [W-1:0] val_v;
    logic [W-1:0] blk_v;

    assign ofs    = BUS_ADDR - BASE_ADDR;
    assign in_win = (BUS_ADDR >= BASE_ADDR) && (ofs <= S_OFS);

    always_comb begin
        val_d    = val_q;
        blk_d    = blk_q;
        div_d    = div_q;
        bright_d = bright_q;
        restart  = 1'b0;
        rd_data  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (ofs == V_OFS + 8'(k)) rd_data = val_q[k];
            if (ofs == B_OFS + 8'(k)) rd_data = blk_q[k];
        end
        if (ofs == D_OFS)  rd_data = div_q;
        if (ofs == BR_OFS) rd_data = bright_q;
        if (ofs == S_OFS)  rd_data = {6'b0, pwm_on, blink_phase};
        if (in_win && BUS_WE) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (ofs == V_OFS + 8'(k)) val_d[k] = BUS_DATA;
                if (ofs == B_OFS + 8'(k)) blk_d[k] = BUS_DATA;
            end
            if (ofs == D_OFS) begin
                div_d   = BUS_DATA;
                restart = 1'b1;
            end
            if (ofs == BR_OFS) bright_d = BUS_DATA;
        end
        oe_d     = in_win && !BUS_WE;
        rd_buf_d = oe_d ? rd_data : rd_buf_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            val_q    <= '0;
            blk_q    <= '0;
            div_q    <= '0;
            bright_q <= BRIGHT_RESET;
            rd_buf_q <= '0;
            oe_q     <= 1'b0;
        end else begin
            val_q    <= val_d;
            blk_q    <= blk_d;
            div_q    <= div_d;
            bright_q <= bright_d;
            rd_buf_q <= rd_buf_d;
            oe_q     <= oe_d;
        end
    end

    led_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk        (CLK),
        .reset      (RESET),
        .blink_div  (div_q),
        .bright     (bright_q),
        .restart    (restart),
        .blink_phase(blink_phase),
        .pwm_on     (pwm_on)
    );

    // Gating with BUS_WE guarantees no contention with a master write.
    assign BUS_DATA = (oe_q && !BUS_WE) ? rd_buf_q : 8'bz;

    assign val_v   = val_q;
    assign blk_v   = blk_q;
    assign LED_OUT = val_v & (~blk_v | {W{blink_phase}}) & {W{pwm_on}};

endmodule
